data_rsp: RTL and testbench

- Responder side of the data read-request interface: accepts address/read-enable beats from the data request generator, drives the data block RAM read port, and realigns the RAM read latency.
- Buffers returned words in a first-word-fall-through FIFO and presents them to the PE datapath with a valid/ready handshake.
- Generates `o_stall` back to the requester so that no accepted read can overflow the buffer.
- Propagates the requester's row-end marker alongside the corresponding data word.

---
 rtl/data_rsp.sv | 116 +++++++++++
 tb/tb_data_rsp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_rsp.sv
// Read responder: drives the data RAM read port, realigns its latency and buffers
// returned words in a FWFT FIFO, with credit-based stall so the buffer cannot overflow.
module data_rsp #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BRAM_LATENCY   = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_CNT_WIDTH = 4,
    parameter int REG_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rden,
    input  logic                  i_end,
    output logic                  o_stall,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic                  o_bram_en,
    input  logic [DATA_WIDTH-1:0] i_bram_dout,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_data_vld,
    input  logic                  i_data_rdy,
    output logic                  o_err,
    output logic [REG_WIDTH-1:0]  dbg_datarsp_fifo_cnt,
    output logic [REG_WIDTH-1:0]  dbg_datarsp_rd_cnt
);
    localparam int STAGES = BRAM_LATENCY - 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } fifo_ent_t;

    logic                      accept, exit_vld, push, pop, empty;
    logic [STAGES:0]           vld_pipe, last_pipe;
    logic [FIFO_CNT_WIDTH-1:0] fifo_cnt, inflight;
    logic [FIFO_CNT_WIDTH:0]   credit;
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [REG_WIDTH-1:0]      rd_cnt;
    fifo_ent_t                 mem [FIFO_DEPTH];

    // Stall looks only at registered counts, so it never depends on i_rden.
    assign credit  = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign o_stall = credit >= (FIFO_CNT_WIDTH+1)'(FIFO_DEPTH);

    assign accept      = i_rden & ~o_stall;
    assign o_bram_en   = accept;
    assign o_bram_addr = i_addr;

    assign exit_vld   = vld_pipe[STAGES];
    assign push       = exit_vld;
    assign empty      = (fifo_cnt == '0);
    assign o_data_vld = ~empty;
    assign pop        = o_data_vld & i_data_rdy;
    assign o_data     = empty ? '0   : mem[rd_ptr].data;
    assign o_last     = empty ? 1'b0 : mem[rd_ptr].last;

    assign dbg_datarsp_fifo_cnt = REG_WIDTH'(fifo_cnt);
    assign dbg_datarsp_rd_cnt   = rd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= (vld_pipe << 1)  | (STAGES+1)'(accept);
            last_pipe <= (last_pipe << 1) | (STAGES+1)'(i_end & accept);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({accept, exit_vld})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Storage is not reset; occupancy and pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{last: last_pipe[STAGES], data: i_bram_dout};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err  <= 1'b0;
            rd_cnt <= '0;
        end else begin
            if (i_rden & o_stall) o_err <= 1'b1;
            if (accept)           rd_cnt <= rd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_data_rsp.sv
// Bench for data_rsp: requester + RAM model drive the DUT, expected words go to a
// queue that a negedge monitor pops whenever the DUT hands over a word.
module tb_data_rsp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_rden = 1'b0;
    logic        i_end = 1'b0;
    logic        o_stall;
    logic [31:0] o_bram_addr;
    logic        o_bram_en;
    logic [31:0] i_bram_dout;
    logic [31:0] o_data;
    logic        o_last;
    logic        o_data_vld;
    logic        i_data_rdy = 1'b0;
    logic        o_err;
    logic [31:0] dbg_datarsp_fifo_cnt;
    logic [31:0] dbg_datarsp_rd_cnt;

    data_rsp dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_rden(i_rden), .i_end(i_end),
        .o_stall(o_stall), .o_bram_addr(o_bram_addr), .o_bram_en(o_bram_en),
        .i_bram_dout(i_bram_dout), .o_data(o_data), .o_last(o_last),
        .o_data_vld(o_data_vld), .i_data_rdy(i_data_rdy), .o_err(o_err),
        .dbg_datarsp_fifo_cnt(dbg_datarsp_fifo_cnt),
        .dbg_datarsp_rd_cnt(dbg_datarsp_rd_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [32:0] exp_q [$];
    int  vld_cnt, first_cyc, last_cyc;
    bit  stall_seen;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return 32'hA0 + a;
    endfunction

    // Two-cycle RAM: address registered, then output registered.
    logic [31:0] ram_q0, ram_q1;
    always @(posedge clk) begin
        ram_q0 <= ram_word(o_bram_addr);
        ram_q1 <= ram_q0;
        cyc    <= cyc + 1;
    end
    assign i_bram_dout = ram_q1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_stall) stall_seen = 1'b1;
            if (o_data_vld) begin
                if (vld_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                vld_cnt++;
                if (i_data_rdy) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_word: got data 0x%0h last %0b, expected none", o_data, o_last);
                    end else begin
                        logic [32:0] e;
                        e = exp_q.pop_front();
                        if ({o_last, o_data} !== e) begin
                            fails++;
                            $display("FAIL word: got last %0b data 0x%0h expected last %0b data 0x%0h",
                                     o_last, o_data, e[32], e[31:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic clr_stats();
        vld_cnt = 0; first_cyc = 0; last_cyc = 0; stall_seen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_rden = 1'b0;
        i_end = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_stall", {31'b0, o_stall}, 0);
        chk("rst_vld", {31'b0, o_data_vld}, 0);
        chk("rst_last", {31'b0, o_last}, 0);
        chk("rst_data", o_data, 0);
        chk("rst_err", {31'b0, o_err}, 0);
        chk("rst_fifo_cnt", dbg_datarsp_fifo_cnt, 0);
        chk("rst_rd_cnt", dbg_datarsp_rd_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clr_stats();
    endtask

    // Well-behaved requester: holds off while stalled, then issues one beat.
    task automatic send(input logic [31:0] addr, input logic last);
        int guard = 0;
        while (o_stall && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            tests++; fails++;
            $display("FAIL send_timeout: stall held %0d cycles, expected release", guard);
        end
        i_rden = 1'b1;
        i_addr = addr;
        i_end  = last;
        exp_q.push_back({last, ram_word(addr)});
        @(negedge clk);
        chk("bram_en", {31'b0, o_bram_en}, 1);
        chk("bram_addr", o_bram_addr, addr);
        @(posedge clk); #1;
        i_rden = 1'b0;
        i_end  = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        do_reset();

        // 1: single read, latency 3
        i_data_rdy = 1'b1;
        send(5, 1'b0);
        @(negedge clk); chk("t1_vld_n1", {31'b0, o_data_vld}, 0);
        @(negedge clk); chk("t1_vld_n2", {31'b0, o_data_vld}, 0);
        @(negedge clk); chk("t1_vld_n3", {31'b0, o_data_vld}, 1);
        chk("t1_data", o_data, 32'hA5);
        @(negedge clk); chk("t1_vld_n4", {31'b0, o_data_vld}, 0);
        chk("t1_stall_seen", {31'b0, stall_seen}, 0);

        // 2: fill with consumer stalled, then drain
        do_reset();
        i_data_rdy = 1'b0;
        @(posedge clk); #1;
        fork
            for (int i = 0; i < 10; i++) send(i, 1'b0);
            begin
                settle(14);
                chk("t2_fifo_full", dbg_datarsp_fifo_cnt, 8);
                chk("t2_stall", {31'b0, o_stall}, 1);
                chk("t2_err", {31'b0, o_err}, 0);
                chk("t2_rd_cnt8", dbg_datarsp_rd_cnt, 8);
                i_data_rdy = 1'b1;
                settle(1);
                chk("t2_stall_drop", {31'b0, o_stall}, 0);
            end
        join
        settle(20);
        chk("t2_q_empty", exp_q.size(), 0);
        chk("t2_fifo_empty", dbg_datarsp_fifo_cnt, 0);
        chk("t2_rd_cnt10", dbg_datarsp_rd_cnt, 10);
        chk("t2_err_end", {31'b0, o_err}, 0);

        // 3: streaming 64 words
        do_reset();
        i_data_rdy = 1'b1;
        for (int i = 0; i < 64; i++) send(32'h100 + i, 1'b0);
        settle(10);
        chk("t3_vld_cnt", vld_cnt, 64);
        chk("t3_contig", last_cyc - first_cyc + 1, 64);
        chk("t3_stall_seen", {31'b0, stall_seen}, 0);
        chk("t3_rd_cnt", dbg_datarsp_rd_cnt, 64);
        chk("t3_q_empty", exp_q.size(), 0);

        // 4: row-end tag on 9th word (scoreboard checks o_last per word)
        do_reset();
        i_data_rdy = 1'b1;
        for (int i = 0; i < 9; i++) send(32'h40 + i, (i == 8));
        settle(10);
        chk("t4_q_empty", exp_q.size(), 0);

        // 5: protocol violation while full
        do_reset();
        i_data_rdy = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h20 + i, 1'b0);
        settle(4);
        chk("t5_stall", {31'b0, o_stall}, 1);
        i_rden = 1'b1;
        i_addr = 32'd50;
        @(negedge clk);
        chk("t5_no_en", {31'b0, o_bram_en}, 0);
        @(posedge clk); #1;
        i_rden = 1'b0;
        chk("t5_err_set", {31'b0, o_err}, 1);
        chk("t5_fifo_cnt", dbg_datarsp_fifo_cnt, 8);
        chk("t5_rd_cnt", dbg_datarsp_rd_cnt, 8);
        i_data_rdy = 1'b1;
        settle(20);
        chk("t5_q_empty", exp_q.size(), 0);
        chk("t5_err_sticky", {31'b0, o_err}, 1);

        // 6: reset with 3 buffered, 2 in flight
        do_reset();
        i_data_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h60 + i, 1'b0);
        chk("t6_fifo_cnt3", dbg_datarsp_fifo_cnt, 3);
        chk("t6_vld_before", {31'b0, o_data_vld}, 1);
        do_reset();
        i_data_rdy = 1'b1;
        settle(12);
        chk("t6_no_stale", vld_cnt, 0);
        chk("t6_fifo_cnt0", dbg_datarsp_fifo_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
